// File: rtl/color_hsv_fsm.sv
// Two-level Moore sequencer: Blue/Red colour FSM with a nested, timed HSV sub-machine.
// Outputs decode registered state only; the run phase is paced by an internal counter.
module color_hsv_fsm #(
  parameter int WIDTH       = 2,
  parameter int HSV_TIMEOUT = 4,
  parameter int RESET_RED   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       state_o,
  output logic             in_hsv
);

  localparam int CW = (HSV_TIMEOUT > 1) ? $clog2(HSV_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    BLUE     = 3'd0,
    RED      = 3'd1,
    HSV_IDLE = 3'd2,
    HSV_RUN  = 3'd3,
    HSV_DONE = 3'd4
  } state_t;

  localparam state_t RESET_STATE = (RESET_RED != 0) ? RED : BLUE;

  localparam logic [WIDTH-1:0] CMD_EXIT   = WIDTH'(0);
  localparam logic [WIDTH-1:0] CMD_TOGGLE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CMD_ENTER  = WIDTH'(2);
  localparam logic [WIDTH-1:0] CMD_START  = WIDTH'(3);
  localparam logic [CW-1:0]    COUNT_LAST = CW'(HSV_TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Counter defaults to zero so it is cleared in every state except a continuing run.
  always_comb begin
    state_next = state_reg;
    count_next = '0;
    case (state_reg)
      BLUE: begin
        if (in_valid && in == CMD_TOGGLE) state_next = RED;
      end
      RED: begin
        if (in_valid && in == CMD_TOGGLE)     state_next = BLUE;
        else if (in_valid && in == CMD_ENTER) state_next = HSV_IDLE;
      end
      HSV_IDLE: begin
        if (in_valid && in == CMD_EXIT)       state_next = RED;
        else if (in_valid && in == CMD_START) state_next = HSV_RUN;
      end
      HSV_RUN: begin
        // Abort has priority over the timeout firing in the same cycle.
        if (in_valid && in == CMD_EXIT) begin
          state_next = RED;
        end else if (count_reg == COUNT_LAST) begin
          state_next = HSV_DONE;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      HSV_DONE: state_next = RED;
      default:  state_next = RESET_STATE;
    endcase
  end

  always_comb begin
    out    = '0;
    in_hsv = 1'b0;
    case (state_reg)
      BLUE:     out = WIDTH'(1);
      RED:      out = WIDTH'(2);
      HSV_IDLE: begin out = WIDTH'(2); in_hsv = 1'b1; end
      HSV_RUN:  begin out = WIDTH'(count_reg); in_hsv = 1'b1; end
      HSV_DONE: begin out = '1; in_hsv = 1'b1; end
      default:  out = '0;
    endcase
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_color_hsv_fsm.sv
// Drives four differently-parameterised instances with shared stimulus and compares
// every cycle against a cycle-level behavioural model of the colour/HSV sequencer.
module tb_color_hsv_fsm;

  localparam int PW [4] = '{2, 2, 2, 4};
  localparam int PT [4] = '{4, 4, 1, 6};
  localparam int PR [4] = '{1, 0, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] cmd = 4'd0;

  logic [1:0] out_a, out_b, out_c;
  logic [3:0] out_d;
  logic [2:0] st [4];
  logic       hsv [4];
  logic [3:0] dout [4];

  int ms [4];
  int mt [4];
  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  color_hsv_fsm #(.WIDTH(2), .HSV_TIMEOUT(4), .RESET_RED(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(cmd[1:0]),
    .out(out_a), .state_o(st[0]), .in_hsv(hsv[0]));
  color_hsv_fsm #(.WIDTH(2), .HSV_TIMEOUT(4), .RESET_RED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(cmd[1:0]),
    .out(out_b), .state_o(st[1]), .in_hsv(hsv[1]));
  color_hsv_fsm #(.WIDTH(2), .HSV_TIMEOUT(1), .RESET_RED(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(cmd[1:0]),
    .out(out_c), .state_o(st[2]), .in_hsv(hsv[2]));
  color_hsv_fsm #(.WIDTH(4), .HSV_TIMEOUT(6), .RESET_RED(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(cmd),
    .out(out_d), .state_o(st[3]), .in_hsv(hsv[3]));

  assign dout[0] = {2'b00, out_a};
  assign dout[1] = {2'b00, out_b};
  assign dout[2] = {2'b00, out_c};
  assign dout[3] = out_d;

  // Model: ms = 0 Blue, 1 Red, 2 idle, 3 run, 4 done; mt = cycles already spent in run.
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ms[i] = (PR[i] != 0) ? 1 : 0;
      mt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int c;
      bit v;
      c = int'(cmd) % (1 << PW[i]);
      v = in_valid;
      if (ms[i] == 0) begin
        if (v && c == 1) ms[i] = 1;
      end else if (ms[i] == 1) begin
        if (v && c == 1) ms[i] = 0;
        else if (v && c == 2) ms[i] = 2;
      end else if (ms[i] == 2) begin
        if (v && c == 0) ms[i] = 1;
        else if (v && c == 3) begin ms[i] = 3; mt[i] = 0; end
      end else if (ms[i] == 3) begin
        if (v && c == 0) ms[i] = 1;
        else if (mt[i] + 1 >= PT[i]) ms[i] = 4;
        else mt[i] = mt[i] + 1;
        if (ms[i] != 3) mt[i] = 0;
      end else begin
        ms[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] eo;
      logic [2:0] es;
      logic       eh;
      case (ms[i])
        0:       eo = 4'(1);
        1, 2:    eo = 4'(2);
        3:       eo = 4'(mt[i] % (1 << PW[i]));
        default: eo = 4'((1 << PW[i]) - 1);
      endcase
      es = 3'(ms[i]);
      eh = (ms[i] >= 2);
      ntotal++;
      assert (dout[i] === eo) npass++;
      else $error("FAIL %s.out inst%0d: observed %0d expected %0d", tag, i, dout[i], eo);
      ntotal++;
      assert (st[i] === es) npass++;
      else $error("FAIL %s.state_o inst%0d: observed %0d expected %0d", tag, i, st[i], es);
      ntotal++;
      assert (hsv[i] === eh) npass++;
      else $error("FAIL %s.in_hsv inst%0d: observed %0d expected %0d", tag, i, hsv[i], eh);
    end
  endtask

  task automatic step(input bit v, input logic [3:0] c, input string tag);
    in_valid = v;
    cmd = c;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a posedge: reset lands mid-cycle, away from any clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    #1 rst_n = 1'b1;

    step(1'b1, 4'd1, "toggle1");
    step(1'b1, 4'd1, "toggle2");
    step(1'b0, 4'd1, "qualify");
    step(1'b1, 4'd2, "enter");
    step(1'b1, 4'd1, "idle_hold1");
    step(1'b1, 4'd2, "idle_hold2");
    step(1'b1, 4'd3, "start");
    for (int k = 0; k < 8; k++) step(1'b0, 4'd0, "run_full");

    step(1'b1, 4'd2, "enter_ab1");
    step(1'b1, 4'd3, "start_ab1");
    step(1'b0, 4'd0, "run_ab1");
    step(1'b1, 4'd0, "abort_c1");
    step(1'b0, 4'd0, "after_ab1");

    step(1'b1, 4'd2, "enter_ab3");
    step(1'b1, 4'd3, "start_ab3");
    for (int k = 0; k < 3; k++) step(1'b0, 4'd0, "run_ab3");
    step(1'b1, 4'd0, "abort_c3");
    step(1'b0, 4'd0, "after_ab3");

    step(1'b1, 4'd2, "enter_rst");
    step(1'b1, 4'd3, "start_rst");
    step(1'b0, 4'd0, "run_rst");
    step(1'b0, 4'd0, "run_rst");
    async_reset("midrun_reset");
    step(1'b0, 4'd0, "post_reset");

    step(1'b1, 4'd2, "enter_exit");
    step(1'b1, 4'd0, "idle_exit");

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), "random");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
